// File: rtl/ysyx_23060208_dsram_pkg.sv
// Shared constants for the data SRAM: AXI response codes, store size codes,
// channel FSM encodings and byte-lane helpers.
package ysyx_23060208_dsram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] WSTRB_WORD = 3'b100;
  localparam logic [2:0] WSTRB_HALF = 3'b010;
  localparam logic [2:0] WSTRB_BYTE = 3'b001;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_DELAY = 2'd1,
    R_RESP  = 2'd2
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_DATA  = 2'd1,
    W_DELAY = 2'd2,
    W_RESP  = 2'd3
  } w_state_e;

  // An all-zero mask marks a size code that is not one-hot.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] off);
    case (size)
      WSTRB_WORD: lane_mask = 4'b1111;
      WSTRB_HALF: lane_mask = 4'b0011 << {off[1], 1'b0};
      WSTRB_BYTE: lane_mask = 4'b0001 << off;
      default:    lane_mask = 4'b0000;
    endcase
  endfunction

  // Replicate LSB-aligned store data so every candidate lane carries it.
  function automatic logic [31:0] lane_data(input logic [2:0] size, input logic [31:0] d);
    case (size)
      WSTRB_HALF: lane_data = {2{d[15:0]}};
      WSTRB_BYTE: lane_data = {4{d[7:0]}};
      default:    lane_data = d;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_23060208_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used to draw response delays.
// Exposes only the low OUT_BITS of the state.
module ysyx_23060208_lfsr #(
  parameter logic [7:0] SEED     = 8'hA5,
  parameter int         OUT_BITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic [OUT_BITS-1:0] rnd
);

  logic [7:0] state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
    end else if (en) begin
      state <= {state[6:0], state[7] ^ state[5] ^ state[4] ^ state[3]};
    end
  end

  assign rnd = state[OUT_BITS-1:0];

endmodule

// File: rtl/ysyx_23060208_dsram.sv
// AXI4-Lite data SRAM with independent read/write channel FSMs, LFSR-driven
// response delay, sub-word store lane placement and LSB-aligned loads.
module ysyx_23060208_dsram
  import ysyx_23060208_dsram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_WORDS  = 4096,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter bit                    RAND_EN    = 1'b1,
  parameter int                    DELAY_BITS = 3,
  parameter logic [7:0]            LFSR_SEED  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] dsram_awaddr,
  input  logic                  dsram_awvalid,
  output logic                  dsram_awready,
  input  logic [DATA_WIDTH-1:0] dsram_wdata,
  input  logic [2:0]            dsram_wstrb,
  input  logic                  dsram_wvalid,
  output logic                  dsram_wready,
  output logic [1:0]            dsram_bresp,
  output logic                  dsram_bvalid,
  input  logic                  dsram_bready,
  input  logic [DATA_WIDTH-1:0] dsram_araddr,
  input  logic                  dsram_arvalid,
  output logic                  dsram_arready,
  output logic [DATA_WIDTH-1:0] dsram_rdata,
  output logic [1:0]            dsram_rresp,
  output logic                  dsram_rvalid,
  input  logic                  dsram_rready,
  output logic [1:0]            r_state_dbg,
  output logic [1:0]            w_state_dbg
);

  // Handshake rule on every channel: a transfer happens on the rising edge
  // where valid and ready are both high; valid, once raised, stays high with
  // data/resp stable until that edge.

  localparam int                    IDX_W = $clog2(MEM_WORDS);
  localparam logic [DATA_WIDTH-1:0] SPAN  = DATA_WIDTH'(4 * MEM_WORDS);

  function automatic logic in_range(input logic [DATA_WIDTH-1:0] a);
    return (a - BASE_ADDR) < SPAN;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [DATA_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  logic [31:0] mem [MEM_WORDS];

  r_state_e r_state, r_next;
  w_state_e w_state, w_next;

  logic [DELAY_BITS-1:0] rnd, delay, r_cnt, w_cnt;
  logic [DATA_WIDTH-1:0] ar_addr_q, aw_addr_q, rd_addr;
  logic                  r_sample, w_commit;
  logic [1:0]            wr_resp;
  logic [3:0]            wr_lanes;
  logic [31:0]           wr_data;

  ysyx_23060208_lfsr #(
    .SEED     (LFSR_SEED),
    .OUT_BITS (DELAY_BITS)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .rnd (rnd)
  );

  assign delay       = RAND_EN ? rnd : '0;
  assign r_state_dbg = r_state;
  assign w_state_dbg = w_state;

  // ---------------- read channel ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next        = r_state;
    dsram_arready = 1'b0;
    dsram_rvalid  = 1'b0;
    r_sample      = 1'b0;
    rd_addr       = ar_addr_q;
    case (r_state)
      R_IDLE: begin
        dsram_arready = 1'b1;
        rd_addr       = dsram_araddr;
        if (dsram_arvalid) begin
          if (delay == '0) begin
            r_next   = R_RESP;
            r_sample = 1'b1;
          end else begin
            r_next = R_DELAY;
          end
        end
      end
      R_DELAY: begin
        if (r_cnt == DELAY_BITS'(1)) begin
          r_next   = R_RESP;
          r_sample = 1'b1;
        end
      end
      R_RESP: begin
        dsram_rvalid = 1'b1;
        if (dsram_rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Sampling uses the pre-edge array, so a same-edge write is not seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      ar_addr_q   <= '0;
      r_cnt       <= '0;
      dsram_rdata <= '0;
      dsram_rresp <= RESP_OKAY;
    end else begin
      if (r_state == R_IDLE && dsram_arvalid) begin
        ar_addr_q <= dsram_araddr;
        r_cnt     <= delay;
      end else if (r_state == R_DELAY) begin
        r_cnt <= r_cnt - DELAY_BITS'(1);
      end
      if (r_sample) begin
        if (in_range(rd_addr)) begin
          dsram_rdata <= mem[word_idx(rd_addr)] >> {rd_addr[1:0], 3'b000};
          dsram_rresp <= RESP_OKAY;
        end else begin
          dsram_rdata <= '0;
          dsram_rresp <= RESP_DECERR;
        end
      end
    end
  end

  // ---------------- write channel ----------------
  always_comb begin
    wr_lanes = lane_mask(dsram_wstrb, aw_addr_q[1:0]);
    wr_data  = lane_data(dsram_wstrb, dsram_wdata);
    wr_resp  = RESP_OKAY;
    if (!in_range(aw_addr_q)) begin
      wr_resp = RESP_DECERR;
    end else if (wr_lanes == 4'b0000) begin
      wr_resp = RESP_SLVERR;
    end else if ((dsram_wstrb == WSTRB_WORD && aw_addr_q[1:0] != 2'b00) ||
                 (dsram_wstrb == WSTRB_HALF && aw_addr_q[0])) begin
      wr_resp = RESP_SLVERR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  always_comb begin
    w_next        = w_state;
    dsram_awready = 1'b0;
    dsram_wready  = 1'b0;
    dsram_bvalid  = 1'b0;
    w_commit      = 1'b0;
    case (w_state)
      W_IDLE: begin
        dsram_awready = 1'b1;
        if (dsram_awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        dsram_wready = 1'b1;
        if (dsram_wvalid) begin
          w_commit = 1'b1;
          w_next   = (delay == '0) ? W_RESP : W_DELAY;
        end
      end
      W_DELAY: begin
        if (w_cnt == DELAY_BITS'(1)) w_next = W_RESP;
      end
      W_RESP: begin
        dsram_bvalid = 1'b1;
        if (dsram_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_addr_q   <= '0;
      w_cnt       <= '0;
      dsram_bresp <= RESP_OKAY;
    end else begin
      if (w_state == W_IDLE && dsram_awvalid) aw_addr_q <= dsram_awaddr;
      if (w_commit) begin
        w_cnt       <= delay;
        dsram_bresp <= wr_resp;
      end else if (w_state == W_DELAY) begin
        w_cnt <= w_cnt - DELAY_BITS'(1);
      end
    end
  end

  // Array has no reset: committed data survives a reset.
  always_ff @(posedge clk) begin
    if (!rst && w_commit && wr_resp == RESP_OKAY) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_lanes[i]) mem[word_idx(aw_addr_q)][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060208_dsram.sv
// Bench for the data SRAM: directed checks on a zero-delay instance, then
// randomized traffic on a random-delay instance against a byte-array model.
module tb_ysyx_23060208_dsram;
  import ysyx_23060208_dsram_pkg::*;

  localparam int          TMO  = 40;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] WIN  = 32'h8000_0100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Shared stimulus; sel routes it to instance 0 (RAND_EN=0) or 1 (RAND_EN=1).
  logic        sel = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [2:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;

  logic [1:0]  awvalid_v, wvalid_v, bready_v, arvalid_v, rready_v;
  logic [1:0]  awready_v, wready_v, bvalid_v, arready_v, rvalid_v;
  logic [1:0]  bresp_v [2];
  logic [1:0]  rresp_v [2];
  logic [31:0] rdata_v [2];
  logic [1:0]  rdbg_v  [2];
  logic [1:0]  wdbg_v  [2];

  assign awvalid_v = {awvalid & sel, awvalid & ~sel};
  assign wvalid_v  = {wvalid  & sel, wvalid  & ~sel};
  assign bready_v  = {bready  & sel, bready  & ~sel};
  assign arvalid_v = {arvalid & sel, arvalid & ~sel};
  assign rready_v  = {rready  & sel, rready  & ~sel};

  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp, rdbg;
  logic [31:0] rdata;
  assign awready = awready_v[sel];
  assign wready  = wready_v[sel];
  assign bvalid  = bvalid_v[sel];
  assign arready = arready_v[sel];
  assign rvalid  = rvalid_v[sel];
  assign bresp   = bresp_v[sel];
  assign rresp   = rresp_v[sel];
  assign rdata   = rdata_v[sel];
  assign rdbg    = rdbg_v[sel];

  ysyx_23060208_dsram #(.RAND_EN(1'b0)) u_dut0 (
    .clk(clk), .rst(rst),
    .dsram_awaddr(awaddr), .dsram_awvalid(awvalid_v[0]), .dsram_awready(awready_v[0]),
    .dsram_wdata(wdata), .dsram_wstrb(wstrb), .dsram_wvalid(wvalid_v[0]), .dsram_wready(wready_v[0]),
    .dsram_bresp(bresp_v[0]), .dsram_bvalid(bvalid_v[0]), .dsram_bready(bready_v[0]),
    .dsram_araddr(araddr), .dsram_arvalid(arvalid_v[0]), .dsram_arready(arready_v[0]),
    .dsram_rdata(rdata_v[0]), .dsram_rresp(rresp_v[0]), .dsram_rvalid(rvalid_v[0]),
    .dsram_rready(rready_v[0]), .r_state_dbg(rdbg_v[0]), .w_state_dbg(wdbg_v[0])
  );

  ysyx_23060208_dsram #(.RAND_EN(1'b1)) u_dut1 (
    .clk(clk), .rst(rst),
    .dsram_awaddr(awaddr), .dsram_awvalid(awvalid_v[1]), .dsram_awready(awready_v[1]),
    .dsram_wdata(wdata), .dsram_wstrb(wstrb), .dsram_wvalid(wvalid_v[1]), .dsram_wready(wready_v[1]),
    .dsram_bresp(bresp_v[1]), .dsram_bvalid(bvalid_v[1]), .dsram_bready(bready_v[1]),
    .dsram_araddr(araddr), .dsram_arvalid(arvalid_v[1]), .dsram_arready(arready_v[1]),
    .dsram_rdata(rdata_v[1]), .dsram_rresp(rresp_v[1]), .dsram_rvalid(rvalid_v[1]),
    .dsram_rready(rready_v[1]), .r_state_dbg(rdbg_v[1]), .w_state_dbg(wdbg_v[1])
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  mb [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic in_map(input logic [31:0] a);
    return a >= BASE && a < BASE + 32'h4000;
  endfunction

  function automatic logic [1:0] exp_wresp(input logic [31:0] a, input logic [2:0] s);
    if (!in_map(a)) return 2'b11;
    case (s)
      3'b100:  return (a % 4 == 0) ? 2'b00 : 2'b10;
      3'b010:  return (a % 2 == 0) ? 2'b00 : 2'b10;
      3'b001:  return 2'b00;
      default: return 2'b10;
    endcase
  endfunction

  // Model window is 64 bytes starting at WIN; stores copy 1/2/4 bytes LSB-first.
  task automatic model_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    int n, bo;
    n  = (s == 3'b100) ? 4 : (s == 3'b010) ? 2 : 1;
    bo = int'(a - WIN);
    if (exp_wresp(a, s) == 2'b00)
      for (int i = 0; i < n; i++) mb[bo + i] = d[8*i +: 8];
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int o;
    if (!in_map(a)) return 32'h0;
    o = int'(a - WIN) & ~3;
    return {mb[o+3], mb[o+2], mb[o+1], mb[o]} >> (8 * int'(a[1:0]));
  endfunction

  // ---------------- driver tasks (entered and left at a falling edge) ----------------
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s,
                          output logic [1:0] resp, output int lat);
    int n = 0;
    awaddr = a; awvalid = 1'b1;
    while (!awready && n < TMO) begin @(negedge clk); n++; end
    if (!awready) chk("aw_timeout", 32'(awready), 32'd1);
    @(negedge clk); awvalid = 1'b0;
    wdata = d; wstrb = s; wvalid = 1'b1;
    n = 0;
    while (!wready && n < TMO) begin @(negedge clk); n++; end
    if (!wready) chk("w_timeout", 32'(wready), 32'd1);
    @(negedge clk); wvalid = 1'b0; bready = 1'b1;
    lat = 1;
    while (!bvalid && lat <= TMO) begin @(negedge clk); lat++; end
    if (!bvalid) chk("b_timeout", 32'(bvalid), 32'd1);
    resp = bresp;
    @(negedge clk); bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input int hold,
                         output logic [31:0] data, output logic [1:0] resp, output int lat);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    while (!arready && n < TMO) begin @(negedge clk); n++; end
    if (!arready) chk("ar_timeout", 32'(arready), 32'd1);
    @(negedge clk); arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat <= TMO) begin @(negedge clk); lat++; end
    if (!rvalid) chk("r_timeout", 32'(rvalid), 32'd1);
    data = rdata; resp = rresp;
    for (int i = 0; i < hold; i++) begin
      chk("ar_blocked", 32'(arready), 32'd0);
      @(negedge clk);
      chk("r_hold_valid", 32'(rvalid), 32'd1);
      chk("r_hold_data", rdata, data);
      chk("r_hold_resp", 32'(rresp), 32'(resp));
    end
    rready = 1'b1;
    @(negedge clk); rready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    logic        found;
    logic [7:0]  seen;

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_awready", 32'(awready), 32'd1);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rresp", 32'(rresp), 32'd0);
    chk("rst_bresp", 32'(bresp), 32'd0);
    chk("rst_rdbg", 32'(rdbg), 32'(R_IDLE));

    // word store then load, zero delay
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 3'b100, r, lat);
    chk("w_word_resp", 32'(r), 32'd0);
    chk("w_word_lat", 32'(lat), 32'd1);
    do_read(32'h8000_0010, 0, d, r, lat);
    chk("r_word_data", d, 32'hDEAD_BEEF);
    chk("r_word_resp", 32'(r), 32'd0);
    chk("r_word_lat", 32'(lat), 32'd1);

    // sub-word placement
    do_write(32'h8000_0020, 32'h0, 3'b100, r, lat);
    do_write(32'h8000_0023, 32'h0000_00AA, 3'b001, r, lat);
    chk("w_byte_resp", 32'(r), 32'd0);
    do_write(32'h8000_0020, 32'h0000_1234, 3'b010, r, lat);
    chk("w_half_resp", 32'(r), 32'd0);
    do_read(32'h8000_0020, 0, d, r, lat);
    chk("r_sub_word", d, 32'hAA00_1234);
    do_read(32'h8000_0023, 0, d, r, lat);
    chk("r_sub_byte", d, 32'h0000_00AA);
    do_read(32'h8000_0022, 0, d, r, lat);
    chk("r_sub_half", d, 32'h0000_AA00);

    // error responses
    do_read(32'h9000_0000, 0, d, r, lat);
    chk("r_dec_resp", 32'(r), 32'd3);
    chk("r_dec_data", d, 32'd0);
    do_read(32'h8000_4000, 0, d, r, lat);
    chk("r_top_resp", 32'(r), 32'd3);
    do_read(32'h8000_3FFC, 0, d, r, lat);
    chk("r_last_resp", 32'(r), 32'd0);
    do_write(32'h8000_0000, 32'h1122_3344, 3'b100, r, lat);
    do_write(32'h8000_0002, 32'hFFFF_FFFF, 3'b100, r, lat);
    chk("w_misal_word", 32'(r), 32'd2);
    do_write(32'h8000_0000, 32'hFFFF_FFFF, 3'b011, r, lat);
    chk("w_bad_strb", 32'(r), 32'd2);
    do_write(32'h8000_0001, 32'hFFFF_FFFF, 3'b010, r, lat);
    chk("w_misal_half", 32'(r), 32'd2);
    do_write(32'h7FFF_FFFC, 32'hFFFF_FFFF, 3'b100, r, lat);
    chk("w_dec_resp", 32'(r), 32'd3);
    do_read(32'h8000_0000, 0, d, r, lat);
    chk("err_unchanged", d, 32'h1122_3344);

    // backpressure
    do_read(32'h8000_0010, 5, d, r, lat);
    chk("bp_data", d, 32'hDEAD_BEEF);
    chk("bp_idle_arready", 32'(arready), 32'd1);
    chk("bp_idle_rvalid", 32'(rvalid), 32'd0);

    // read sample and write commit on the same edge
    awaddr = 32'h8000_0010; wstrb = 3'b100; awvalid = 1'b1;
    @(negedge clk); awvalid = 1'b0;
    wdata = 32'h0BAD_F00D; wvalid = 1'b1; araddr = 32'h8000_0010; arvalid = 1'b1;
    chk("cc_wready", 32'(wready), 32'd1);
    chk("cc_arready", 32'(arready), 32'd1);
    @(negedge clk); wvalid = 1'b0; arvalid = 1'b0;
    chk("cc_rvalid", 32'(rvalid), 32'd1);
    chk("cc_old_data", rdata, 32'hDEAD_BEEF);
    chk("cc_bvalid", 32'(bvalid), 32'd1);
    rready = 1'b1; bready = 1'b1;
    @(negedge clk); rready = 1'b0; bready = 1'b0;
    do_read(32'h8000_0010, 0, d, r, lat);
    chk("cc_new_data", d, 32'h0BAD_F00D);

    // reset while the random-delay instance is counting down
    sel = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      araddr = 32'h8000_0000; arvalid = 1'b1;
      @(negedge clk); arvalid = 1'b0;
      if (rvalid) begin
        rready = 1'b1; @(negedge clk); rready = 1'b0;
      end else begin
        found = 1'b1;
      end
    end
    chk("delay_found", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
    chk("mid_rst_arready", 32'(arready), 32'd1);
    chk("mid_rst_rdbg", 32'(rdbg), 32'(R_IDLE));
    sel = 1'b0;
    do_read(32'h8000_0010, 0, d, r, lat);
    chk("persist_data", d, 32'h0BAD_F00D);

    // randomized traffic with random delays
    sel = 1'b1;
    seen = '0;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      model_write(WIN + 32'(4 * i), 3'b100, d);
      do_write(WIN + 32'(4 * i), d, 3'b100, r, lat);
      chk("init_resp", 32'(r), 32'd0);
    end
    for (int k = 0; k < 1000; k++) begin
      logic [31:0] a, wd;
      logic [2:0]  s;
      int          pick;
      pick = $urandom_range(0, 9);
      if (pick == 0) begin
        case ($urandom_range(0, 2))
          0:       a = 32'h9000_0000 + 32'($urandom_range(0, 255));
          1:       a = 32'h7FFF_FFF0 + 32'($urandom_range(0, 15));
          default: a = 32'h8000_4000 + 32'($urandom_range(0, 15));
        endcase
      end else begin
        a = WIN + 32'($urandom_range(0, 63));
      end
      if ($urandom_range(0, 1) == 0) begin
        exp_q.push_back(model_read(a));
        do_read(a, $urandom_range(0, 2), d, r, lat);
        chk("rnd_rdata", d, exp_q.pop_front());
        chk("rnd_rresp", 32'(r), in_map(a) ? 32'd0 : 32'd3);
      end else begin
        case ($urandom_range(0, 9))
          0, 1, 2: s = 3'b100;
          3, 4, 5: s = 3'b010;
          6, 7, 8: s = 3'b001;
          default: begin
            s = 3'($urandom_range(0, 7));
            if (s == 3'b100 || s == 3'b010 || s == 3'b001) s = 3'b011;
          end
        endcase
        wd = $urandom;
        do_write(a, wd, s, r, lat);
        chk("rnd_bresp", 32'(r), 32'(exp_wresp(a, s)));
        model_write(a, s, wd);
      end
      chk("rnd_lat_range", 32'(lat >= 1 && lat <= 8), 32'd1);
      if (lat >= 1 && lat <= 8) seen[lat-1] = 1'b1;
    end
    chk("delay_span", 32'(seen), 32'h0000_00FF);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
